// File: rtl/dfi_protocol_monitor.sv
// rtl/dfi_protocol_monitor.sv - passive DFI protocol checker with sticky error flags
// Define DFI_MON_CNT_EN to add saturating WR/RD/ctrlupd-grant counters.
module dfi_protocol_monitor #(
  parameter int NUM_RANKS     = 4,
  parameter int NUM_SLICES    = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int BANK_WIDTH    = 3,
  parameter int TPHY_WRLAT    = 4,
  parameter int TRDDATA_EN    = 4,
  parameter int TPHY_RDLAT    = 16,
  parameter int TCTRLUPD_MAX  = 64,
  parameter int RD_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] dfi_address,
  input  logic [BANK_WIDTH-1:0] dfi_bank,
  input  logic [NUM_RANKS-1:0]  dfi_cs_n,
  input  logic                  dfi_ras_n,
  input  logic                  dfi_cas_n,
  input  logic                  dfi_we_n,
  input  logic [NUM_SLICES-1:0] dfi_wrdata_en,
  input  logic [NUM_SLICES-1:0] dfi_rddata_en,
  input  logic                  dfi_rddata_valid,
  input  logic                  dfi_ctrlupd_req,
  input  logic                  dfi_ctrlupd_ack,
  input  logic                  dfi_init_complete,
  input  logic                  clr_err,
`ifdef DFI_MON_CNT_EN
  output logic [31:0]           wr_cmd_cnt,
  output logic [31:0]           rd_cmd_cnt,
  output logic [31:0]           ctrlupd_cnt,
`endif
  output logic [6:0]            err_vec,
  output logic                  err_any,
  output logic [2:0]            first_err
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int TW = $clog2(TCTRLUPD_MAX + 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(RD_FIFO_DEPTH);
  localparam logic [7:0]    RDLAT8   = 8'(TPHY_RDLAT);
  localparam logic [TW-1:0] UPD_MAX  = TW'(TCTRLUPD_MAX);
  localparam logic [TW-1:0] UPD_LAST = TW'(TCTRLUPD_MAX - 1);

  typedef enum logic [1:0] {UPD_IDLE, UPD_REQ, UPD_ACK} upd_state_e;

  logic [NUM_RANKS-1:0]  cs_act;
  logic                  non_nop, wr_cmd, rd_cmd, multi_cs;
  logic [TPHY_WRLAT-1:0] wr_sr_q, wr_sr_d;
  logic [TRDDATA_EN-1:0] rd_sr_q, rd_sr_d;
  logic [7:0]            now_q, age;
  logic [7:0]            fifo_q [RD_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  push, pop, empty, full, timeout, enq, deq, underflow, overflow;
  upd_state_e            upd_state_q;
  logic [TW-1:0]         upd_timer_q;
  logic                  upd_err;
  logic [6:0]            new_err, err_vec_q, err_vec_d;
  logic [2:0]            first_err_q, first_err_d, low_idx;
  logic                  unused_ok;

  assign unused_ok = ^{dfi_address, dfi_bank};

  always_comb begin
    cs_act   = ~dfi_cs_n;
    non_nop  = (|cs_act) && !(dfi_ras_n && dfi_cas_n && dfi_we_n);
    wr_cmd   = (|cs_act) && dfi_ras_n && !dfi_cas_n && !dfi_we_n;
    rd_cmd   = (|cs_act) && dfi_ras_n && !dfi_cas_n && dfi_we_n;
    multi_cs = (cs_act & (cs_act - NUM_RANKS'(1))) != '0;
    wr_sr_d  = (wr_sr_q << 1) | TPHY_WRLAT'(wr_cmd);
    rd_sr_d  = (rd_sr_q << 1) | TRDDATA_EN'(rd_cmd);
  end

  // Read-burst timestamps: a timed-out head is dropped, and a same-cycle valid retires that entry.
  always_comb begin
    push      = |dfi_rddata_en;
    pop       = dfi_rddata_valid;
    empty     = (cnt_q == '0);
    full      = (cnt_q == CNT_FULL);
    age       = now_q - fifo_q[rd_ptr_q];
    timeout   = !empty && (age > RDLAT8);
    deq       = !empty && (pop || timeout);
    enq       = push && !(full && !deq) && !(empty && pop);
    underflow = pop && empty && !push;
    overflow  = push && full && !deq;
    cnt_d     = cnt_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sr_q  <= '0;
      rd_sr_q  <= '0;
      now_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wr_sr_q <= wr_sr_d;
      rd_sr_q <= rd_sr_d;
      now_q   <= now_q + 8'd1;
      cnt_q   <= cnt_d;
      if (enq) begin
        fifo_q[wr_ptr_q] <= now_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_state_q <= UPD_IDLE;
      upd_timer_q <= '0;
    end else begin
      case (upd_state_q)
        UPD_IDLE: begin
          upd_timer_q <= '0;
          if (dfi_ctrlupd_req) upd_state_q <= UPD_REQ;
        end
        UPD_REQ: begin
          if (!dfi_ctrlupd_req)     upd_state_q <= UPD_IDLE;
          else if (dfi_ctrlupd_ack) upd_state_q <= UPD_ACK;
        end
        UPD_ACK: if (!dfi_ctrlupd_req) upd_state_q <= UPD_IDLE;
        default: upd_state_q <= UPD_IDLE;
      endcase
      if (upd_state_q != UPD_IDLE && upd_timer_q != UPD_MAX)
        upd_timer_q <= upd_timer_q + 1'b1;
    end
  end

  always_comb begin
    upd_err = 1'b0;
    if (upd_state_q == UPD_IDLE) upd_err = dfi_ctrlupd_ack;
    else if (upd_timer_q == UPD_LAST) upd_err = 1'b1;

    new_err = {non_nop && (multi_cs || !dfi_init_complete),
               upd_err,
               timeout,
               underflow || overflow,
               rd_sr_q[TRDDATA_EN-1] != (|dfi_rddata_en),
               (|dfi_wrdata_en) && !(&dfi_wrdata_en),
               wr_sr_q[TPHY_WRLAT-1] != (|dfi_wrdata_en)};

    low_idx = 3'd0;
    for (int i = 6; i >= 0; i--) if (new_err[i]) low_idx = 3'(i);

    err_vec_d   = (clr_err ? 7'd0 : err_vec_q) | new_err;
    first_err_d = clr_err ? 3'd0 : first_err_q;
    if ((clr_err || err_vec_q == '0) && new_err != '0) first_err_d = low_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_vec_q   <= '0;
      first_err_q <= '0;
    end else begin
      err_vec_q   <= err_vec_d;
      first_err_q <= first_err_d;
    end
  end

  assign err_vec   = err_vec_q;
  assign err_any   = |err_vec_q;
  assign first_err = first_err_q;

`ifdef DFI_MON_CNT_EN
  logic [31:0] wr_cnt_q, rd_cnt_q, upd_cnt_q;
  logic        upd_grant;

  assign upd_grant = (upd_state_q == UPD_REQ) && dfi_ctrlupd_req && dfi_ctrlupd_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      upd_cnt_q <= '0;
    end else begin
      if (wr_cmd && wr_cnt_q != '1)     wr_cnt_q  <= wr_cnt_q + 32'd1;
      if (rd_cmd && rd_cnt_q != '1)     rd_cnt_q  <= rd_cnt_q + 32'd1;
      if (upd_grant && upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 32'd1;
    end
  end

  assign wr_cmd_cnt  = wr_cnt_q;
  assign rd_cmd_cnt  = rd_cnt_q;
  assign ctrlupd_cnt = upd_cnt_q;
`endif

endmodule

// File: tb/tb_dfi_protocol_monitor.sv
// tb/tb_dfi_protocol_monitor.sv - directed bench with scheduled-event model for dfi_protocol_monitor
module tb_dfi_protocol_monitor;

  localparam int WRLAT = 4, RDEN = 4, RDLAT = 16, UPDMAX = 64, DEPTH = 8, N = 4096;
  localparam logic [2:0] WR_C = 3'b100, RD_C = 3'b101, MRS_C = 3'b000, NOP_C = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic [3:0]  dfi_cs_n;
  logic        dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [3:0]  dfi_wrdata_en, dfi_rddata_en;
  logic        dfi_rddata_valid, dfi_ctrlupd_req, dfi_ctrlupd_ack, dfi_init_complete, clr_err;
  logic [6:0]  err_vec;
  logic        err_any;
  logic [2:0]  first_err;
`ifdef DFI_MON_CNT_EN
  logic [31:0] wr_cmd_cnt, rd_cmd_cnt, ctrlupd_cnt;
`endif

  always #5 clk = ~clk;

  dfi_protocol_monitor dut (
    .clk(clk), .reset_n(reset_n), .dfi_address(dfi_address), .dfi_bank(dfi_bank),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en),
    .dfi_rddata_valid(dfi_rddata_valid), .dfi_ctrlupd_req(dfi_ctrlupd_req),
    .dfi_ctrlupd_ack(dfi_ctrlupd_ack), .dfi_init_complete(dfi_init_complete),
    .clr_err(clr_err),
`ifdef DFI_MON_CNT_EN
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt), .ctrlupd_cnt(ctrlupd_cnt),
`endif
    .err_vec(err_vec), .err_any(err_any), .first_err(first_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scheduled enable due-times, a queue of absolute push cycles, and update-session bookkeeping.
  int          cyc = 0;
  bit          due_wr [N];
  bit          due_rd [N];
  int          rdq [$];
  bit          upd_on, upd_acked;
  int          upd_cycles;
  logic [6:0]  m_err;
  logic [2:0]  m_first;
  int          m_wr_cnt, m_rd_cnt, m_upd_cnt;

  function automatic logic [2:0] lowest(input logic [6:0] e);
    for (int i = 0; i < 7; i++) if (e[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_step();
    logic [6:0] e;
    bit sel, nonnop, wr, rd, removed, push, pop;
    e      = '0;
    sel    = (dfi_cs_n != 4'hF);
    nonnop = sel && ({dfi_ras_n, dfi_cas_n, dfi_we_n} != NOP_C);
    wr     = sel && ({dfi_ras_n, dfi_cas_n, dfi_we_n} == WR_C);
    rd     = sel && ({dfi_ras_n, dfi_cas_n, dfi_we_n} == RD_C);
    if (nonnop && ($countones(~dfi_cs_n) > 1 || !dfi_init_complete)) e[6] = 1'b1;
    if (due_wr[cyc % N] != (dfi_wrdata_en != 4'h0)) e[0] = 1'b1;
    if (dfi_wrdata_en != 4'h0 && dfi_wrdata_en != 4'hF) e[1] = 1'b1;
    if (due_rd[cyc % N] != (dfi_rddata_en != 4'h0)) e[2] = 1'b1;
    due_wr[cyc % N] = 1'b0;
    due_rd[cyc % N] = 1'b0;
    if (wr) begin due_wr[(cyc + WRLAT) % N] = 1'b1; m_wr_cnt++; end
    if (rd) begin due_rd[(cyc + RDEN) % N] = 1'b1; m_rd_cnt++; end

    push = (dfi_rddata_en != 4'h0);
    pop  = dfi_rddata_valid;
    removed = 1'b0;
    if (rdq.size() > 0 && (cyc - rdq[0]) > RDLAT) begin
      e[4] = 1'b1;
      void'(rdq.pop_front());
      removed = 1'b1;
    end
    if (pop && !removed) begin
      if (rdq.size() > 0) void'(rdq.pop_front());
      else if (push) push = 1'b0;
      else e[3] = 1'b1;
    end
    if (push) begin
      if (rdq.size() >= DEPTH) e[3] = 1'b1;
      else rdq.push_back(cyc);
    end

    if (!upd_on) begin
      if (dfi_ctrlupd_ack) e[5] = 1'b1;
      if (dfi_ctrlupd_req) begin upd_on = 1'b1; upd_acked = 1'b0; upd_cycles = 0; end
    end else begin
      upd_cycles++;
      if (upd_cycles == UPDMAX) e[5] = 1'b1;
      if (!dfi_ctrlupd_req) upd_on = 1'b0;
      else if (!upd_acked && dfi_ctrlupd_ack) begin upd_acked = 1'b1; m_upd_cnt++; end
    end

    if (clr_err) begin
      m_err   = e;
      m_first = lowest(e);
    end else begin
      if (m_err == '0 && e != '0) m_first = lowest(e);
      m_err = m_err | e;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_err = '0; m_first = '0; upd_on = 0; upd_acked = 0; upd_cycles = 0;
      m_wr_cnt = 0; m_rd_cnt = 0; m_upd_cnt = 0;
      rdq.delete();
      foreach (due_wr[i]) begin due_wr[i] = 1'b0; due_rd[i] = 1'b0; end
    end else begin
      model_step();
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("err_vec", err_vec, m_err);
    check("err_any", err_any, |m_err);
    check("first_err", first_err, m_first);
`ifdef DFI_MON_CNT_EN
    check("wr_cmd_cnt", wr_cmd_cnt, m_wr_cnt);
    check("rd_cmd_cnt", rd_cmd_cnt, m_rd_cnt);
    check("ctrlupd_cnt", ctrlupd_cnt, m_upd_cnt);
`endif
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_idle();
    dfi_cs_n = 4'hF; {dfi_ras_n, dfi_cas_n, dfi_we_n} = NOP_C;
    dfi_wrdata_en = '0; dfi_rddata_en = '0; dfi_rddata_valid = 0; clr_err = 0;
  endtask

  task automatic nop(input int n); repeat (n) begin set_idle(); tick(); end endtask

  task automatic cmd(input logic [3:0] cs, input logic [2:0] rcw);
    set_idle(); dfi_cs_n = cs; {dfi_ras_n, dfi_cas_n, dfi_we_n} = rcw; tick();
  endtask

  task automatic clear(); set_idle(); clr_err = 1; tick(); clr_err = 0; endtask

  initial begin
    reset_n = 0; dfi_init_complete = 1; dfi_ctrlupd_req = 0; dfi_ctrlupd_ack = 0;
    dfi_address = 16'h0123; dfi_bank = 3'd2; set_idle();
    repeat (3) tick();
    check("reset_err_vec", err_vec, 0);
    check("reset_err_any", err_any, 0);
    check("reset_first_err", first_err, 0);
    reset_n = 1; tick();

    cmd(4'b1110, WR_C); nop(3); set_idle(); dfi_wrdata_en = 4'hF; tick(); nop(3);
    check("wr_on_time", err_vec, 7'h00);
    cmd(4'b1110, WR_C); nop(4); set_idle(); dfi_wrdata_en = 4'hF; tick(); nop(2);
    check("wr_late_vec", err_vec, 7'h01);
    check("wr_late_first", first_err, 0);
    clear();

    cmd(4'b1110, RD_C); nop(3); set_idle(); dfi_rddata_en = 4'hF; tick();
    nop(9); set_idle(); dfi_rddata_valid = 1; tick(); nop(2);
    check("rd_valid_10", err_vec, 7'h00);
    cmd(4'b1101, RD_C); nop(3); set_idle(); dfi_rddata_en = 4'hF; tick();
    nop(16); set_idle(); dfi_rddata_valid = 1; tick(); nop(2);
    check("rd_valid_17", err_vec, 7'h10);
    check("rd_valid_17_first", first_err, 4);
    clear();

    repeat (8) begin set_idle(); dfi_rddata_en = 4'hF; tick(); end
    check("fifo_8_no_ovf", err_vec[3], 0);
    set_idle(); dfi_rddata_en = 4'hF; tick();
    check("fifo_9_ovf", err_vec[3], 1);
    check("fifo_first", first_err, 2);
    nop(20); clear();

    dfi_ctrlupd_req = 1; nop(2); dfi_ctrlupd_ack = 1; nop(1);
    dfi_ctrlupd_req = 0; nop(1); dfi_ctrlupd_ack = 0; nop(2);
    check("upd_handshake", err_vec, 7'h00);
    dfi_ctrlupd_req = 1; nop(63); dfi_ctrlupd_req = 0; nop(3);
    check("upd_63_ok", err_vec, 7'h00);
    dfi_ctrlupd_req = 1; nop(64); dfi_ctrlupd_req = 0; nop(3);
    check("upd_64_timeout", err_vec, 7'h20);
    check("upd_64_first", first_err, 5);
    clear();
    dfi_ctrlupd_ack = 1; nop(1); dfi_ctrlupd_ack = 0; nop(2);
    check("upd_ack_no_req", err_vec, 7'h20);
    clear();

    cmd(4'b1110, WR_C); nop(3); set_idle(); dfi_wrdata_en = 4'h3; tick(); nop(2);
    check("wr_partial", err_vec, 7'h02);
    check("wr_partial_first", first_err, 1);
    clear();

    cmd(4'b1100, RD_C); nop(3); set_idle(); dfi_rddata_en = 4'hF; tick();
    nop(5); set_idle(); dfi_rddata_valid = 1; tick(); nop(2);
    check("multi_cs", err_vec, 7'h40);
    check("multi_cs_first", first_err, 6);
    clear();
    check("clr_err_vec", err_vec, 7'h00);
    check("clr_err_any", err_any, 0);

    dfi_init_complete = 0; cmd(4'b1110, NOP_C); nop(1);
    check("nop_before_init", err_vec, 7'h00);
    cmd(4'b1110, MRS_C); dfi_init_complete = 1; nop(2);
    check("cmd_before_init", err_vec, 7'h40);
    clear();

    cmd(4'b1110, RD_C); cmd(4'b1110, RD_C); cmd(4'b1110, RD_C); cmd(4'b1110, WR_C);
    repeat (3) begin set_idle(); dfi_rddata_en = 4'hF; tick(); end
    set_idle(); reset_n = 0; tick(); tick();
    reset_n = 1; nop(25);
    check("reset_mid_burst", err_vec, 7'h00);

    for (int i = 0; i < 9; i++) begin
      set_idle();
      if (i < 5) begin dfi_cs_n = 4'b0111; {dfi_ras_n, dfi_cas_n, dfi_we_n} = WR_C; end
      if (i >= 4) dfi_wrdata_en = 4'hF;
      tick();
    end
    nop(2);
    check("wr_back_to_back", err_vec, 7'h00);
`ifdef DFI_MON_CNT_EN
    check("wr_cnt_5", wr_cmd_cnt, 5);
    check("rd_cnt_0", rd_cmd_cnt, 0);
`endif

    set_idle(); dfi_rddata_valid = 1; tick(); nop(1);
    check("valid_empty_after_reset", err_vec, 7'h08);
    check("valid_empty_first", first_err, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
